// File: rtl/mdr_control_if.sv
// mdr_control_if: request, control and status bundle between requester and MDR sequencer
interface mdr_control_if #(
  parameter int DW_MDR = 16,
  parameter int CNT_W = $clog2(DW_MDR) + 1
);
  logic start;
  logic [1:0] op_sel_in;
  logic op_b_zero;
  logic ack;
  logic [1:0] op_sel;
  logic enable;
  logic ready;
  logic load;
  logic shift_enable;
  logic [CNT_W-1:0] iter;
  logic busy;
  logic error;
  modport master (
    output start, op_sel_in, op_b_zero, ack,
    input op_sel, enable, ready, load, shift_enable, iter, busy, error
  );
  modport slave (
    input start, op_sel_in, op_b_zero, ack,
    output op_sel, enable, ready, load, shift_enable, iter, busy, error
  );
endinterface

// File: rtl/mdr_control.sv
// mdr_control: Moore sequencer driving the MDR operands register through load, iterate and handoff
module mdr_control #(
  parameter int DW_MDR = 16,
  parameter int CNT_W = $clog2(DW_MDR) + 1
) (
  input logic clk,
  input logic rst,
  mdr_control_if.slave bus
);
  localparam logic [1:0] MULT = 2'd0;
  localparam logic [1:0] DIV = 2'd1;
  localparam logic [1:0] SQRT = 2'd2;
  localparam logic [CNT_W-1:0] LAST_F = CNT_W'(DW_MDR - 1);
  localparam logic [CNT_W-1:0] LAST_H = CNT_W'(DW_MDR / 2 - 1);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, ERR} state_t;
  state_t st, nxt;
  logic [1:0] op;
  logic [CNT_W-1:0] it;
  logic last, bad;
  assign last = it == (op == SQRT ? LAST_H : LAST_F);
  assign bad = bus.op_sel_in > SQRT || (bus.op_sel_in == DIV && bus.op_b_zero);
  // state register
  always_ff @(posedge clk)
    if (!rst) st <= IDLE;
    else st <= nxt;
  // latched operation and iteration counter; counter zeroed on entry to LOAD so LOAD and first RUN show 0
  always_ff @(posedge clk)
    if (!rst) begin
      op <= MULT;
      it <= '0;
    end else begin
      if (st == IDLE && bus.start) op <= bus.op_sel_in;
      if (nxt == LOAD) it <= '0;
      else if (st == RUN && !last) it <= it + 1'b1;
    end
  // next-state decode; unused encodings fall back to IDLE
  always_comb begin
    nxt = IDLE;
    case (st)
      IDLE: nxt = !bus.start ? IDLE : bad ? ERR : LOAD;
      LOAD: nxt = RUN;
      RUN: nxt = last ? DONE : RUN;
      DONE: nxt = bus.ack ? IDLE : DONE;
      ERR: nxt = bus.ack ? IDLE : ERR;
      default: nxt = IDLE;
    endcase
  end
  // Moore outputs from registered state, op and counter
  always_comb begin
    bus.enable = st == LOAD || st == RUN;
    bus.load = st == LOAD;
    bus.shift_enable = st == RUN && op == DIV;
    bus.ready = st == DONE;
    bus.error = st == ERR;
    bus.busy = st == LOAD || st == RUN || st == DONE || st == ERR;
    bus.iter = it;
    bus.op_sel = op;
  end
endmodule
